// File: rtl/pipe_ctrl_if.sv
// Stall/flush bus between the pipeline stages (master) and the pipe_ctrl controller (slave).
// Carries stall requests, the flush handshake, and the controller's status counters.
interface pipe_ctrl_if #(
   parameter int STAGES = 5,
   parameter int CNT_W  = 32
);
   localparam int SW = $clog2(STAGES);

   logic              rdy_in;
   logic [STAGES-1:0] stall_req;
   logic              flush_req;
   logic [SW-1:0]     flush_stage;
   logic              flush_ack;
   logic [STAGES-1:0] stall;
   logic [STAGES-1:0] flush;
   logic [CNT_W-1:0]  stall_cycles;
   logic [CNT_W-1:0]  flush_count;
   logic              hang;

   modport master (
      output rdy_in, stall_req, flush_req, flush_stage,
      input  flush_ack, stall, flush, stall_cycles, flush_count, hang
   );

   modport slave (
      input  rdy_in, stall_req, flush_req, flush_stage,
      output flush_ack, stall, flush, stall_cycles, flush_count, hang
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for an in-order pipeline: thermometer stalls, acked flushes with an
// IF flush hold, saturating performance counters and a sticky hang watchdog.
module pipe_ctrl #(
   parameter int STAGES     = 5,
   parameter int FLUSH_HOLD = 2,
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 1024
) (
   input logic        clk_in,
   input logic        rst_in,
   pipe_ctrl_if.slave bus
);
   localparam int HC_W = 4;
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state_q, state_d;
   logic [HC_W-1:0]   holdCnt_q, holdCnt_d;
   logic [CNT_W-1:0]  stallCycles_q, stallCycles_d;
   logic [CNT_W-1:0]  flushCount_q, flushCount_d;
   logic [WD_W-1:0]   wdogCnt_q, wdogCnt_d;
   logic              hang_q, hang_d;

   logic [STAGES-1:0] thermo;
   logic [STAGES-1:0] youngerMask;
   logic [STAGES-1:0] flushVec;
   logic [STAGES-1:0] flushOut;
   logic [STAGES-1:0] stallOut;
   logic              active;
   logic              anyReq;
   logic              blocked;
   logic              validStage;
   logic              accept;
   logic              run;

   // Thermometer stall plus the stage masks used to decide whether a flush may be accepted.
   always_comb begin
      run         = 1'b0;
      thermo      = '0;
      youngerMask = '0;
      for (int j = STAGES - 1; j >= 0; j--) begin
         run       = run | bus.stall_req[j];
         thermo[j] = run;
      end
      for (int j = 0; j < STAGES; j++) begin
         youngerMask[j] = (j < int'(bus.flush_stage));
      end
      active     = bus.rdy_in & ~rst_in;
      anyReq     = |bus.stall_req;
      blocked    = |(bus.stall_req & ~youngerMask);
      validStage = (bus.flush_stage != '0) && (int'(bus.flush_stage) < STAGES);
      accept     = bus.flush_req & active & ~blocked;
      flushVec   = (accept && validStage) ? youngerMask : '0;
   end

   // Flushes override stalls of the same stage; a pause or reset freezes everything to full stall.
   always_comb begin
      flushOut = '0;
      stallOut = '1;
      if (active) begin
         flushOut    = flushVec;
         flushOut[0] = flushVec[0] | (state_q == HOLD);
         stallOut    = thermo & ~flushOut;
      end
   end

   assign bus.stall        = stallOut;
   assign bus.flush        = flushOut;
   assign bus.flush_ack    = accept;
   assign bus.stall_cycles = stallCycles_q;
   assign bus.flush_count  = flushCount_q;
   assign bus.hang         = hang_q;

   // Next-state for the hold FSM, counters and watchdog; nothing moves on a paused cycle.
   always_comb begin
      state_d       = state_q;
      holdCnt_d     = holdCnt_q;
      stallCycles_d = stallCycles_q;
      flushCount_d  = flushCount_q;
      wdogCnt_d     = wdogCnt_q;
      hang_d        = hang_q;
      if (active) begin
         if (accept && validStage && (FLUSH_HOLD > 1)) begin
            state_d   = HOLD;
            holdCnt_d = HC_W'(FLUSH_HOLD - 1);
         end else if (state_q == HOLD) begin
            if (holdCnt_q <= HC_W'(1)) begin
               state_d   = IDLE;
               holdCnt_d = '0;
            end else begin
               holdCnt_d = holdCnt_q - HC_W'(1);
            end
         end
         if (anyReq && (stallCycles_q != '1)) begin
            stallCycles_d = stallCycles_q + CNT_W'(1);
         end
         if (accept && (flushCount_q != '1)) begin
            flushCount_d = flushCount_q + CNT_W'(1);
         end
         if (!anyReq) begin
            wdogCnt_d = '0;
         end else if (wdogCnt_q != WD_W'(TIMEOUT)) begin
            wdogCnt_d = wdogCnt_q + WD_W'(1);
         end
         if (wdogCnt_d == WD_W'(TIMEOUT)) begin
            hang_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= IDLE;
         holdCnt_q     <= '0;
         stallCycles_q <= '0;
         flushCount_q  <= '0;
         wdogCnt_q     <= '0;
         hang_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         holdCnt_q     <= holdCnt_d;
         stallCycles_q <= stallCycles_d;
         flushCount_q  <= flushCount_d;
         wdogCnt_q     <= wdogCnt_d;
         hang_q        <= hang_d;
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl (STAGES=5, FLUSH_HOLD=2, CNT_W=8, TIMEOUT=8): a vector table fed through
// a scoreboard queue, plus hand sequences for reset-abort, watchdog and counter saturation.
module tb_pipe_ctrl;
   localparam int STAGES = 5;
   localparam int CNT_W  = 8;

   typedef struct {
      logic       rdy;
      logic [4:0] sreq;
      logic       freq;
      logic [2:0] fstage;
      logic [4:0] eStall;
      logic [4:0] eFlush;
      logic       eAck;
      logic [7:0] eSc;
      logic [7:0] eFc;
      logic       eHang;
   } vec_t;

   logic   clk_in = 1'b0;
   logic   rst_in;
   int     vectors = 0;
   int     miscompares = 0;
   vec_t   tbl[27];
   vec_t   expQ[$];

   pipe_ctrl_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

   pipe_ctrl #(
      .STAGES(STAGES), .FLUSH_HOLD(2), .CNT_W(CNT_W), .TIMEOUT(8)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .bus(bus)
   );

   always #5 clk_in = ~clk_in;

   function automatic vec_t mk(input logic rdy, input logic [4:0] sreq, input logic freq,
                               input logic [2:0] fs, input logic [4:0] eStall,
                               input logic [4:0] eFlush, input logic eAck,
                               input logic [7:0] eSc, input logic [7:0] eFc);
      vec_t v;
      v.rdy = rdy;       v.sreq = sreq;     v.freq = freq;   v.fstage = fs;
      v.eStall = eStall; v.eFlush = eFlush; v.eAck = eAck;
      v.eSc = eSc;       v.eFc = eFc;       v.eHang = 1'b0;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of input: drive just after the rising edge.
   task automatic drive(input logic rdy, input logic [4:0] sreq, input logic freq,
                        input logic [2:0] fs);
      @(posedge clk_in);
      #1;
      bus.rdy_in = rdy; bus.stall_req = sreq; bus.flush_req = freq; bus.flush_stage = fs;
   endtask

   task automatic applyStimulus(input vec_t v);
      drive(v.rdy, v.sreq, v.freq, v.fstage);
      expQ.push_back(v);
   endtask

   task automatic checkOutput(input int idx);
      vec_t e;
      @(negedge clk_in);
      if (expQ.size() == 0) begin
         cmp($sformatf("queue_empty[%0d]", idx), 1, 0);
      end else begin
         e = expQ.pop_front();
         cmp($sformatf("stall[%0d]", idx), bus.stall, e.eStall);
         cmp($sformatf("flush[%0d]", idx), bus.flush, e.eFlush);
         cmp($sformatf("ack[%0d]", idx), bus.flush_ack, e.eAck);
         cmp($sformatf("stall_cycles[%0d]", idx), bus.stall_cycles, e.eSc);
         cmp($sformatf("flush_count[%0d]", idx), bus.flush_count, e.eFc);
         cmp($sformatf("hang[%0d]", idx), bus.hang, e.eHang);
      end
   endtask

   task automatic doReset();
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      bus.rdy_in = 1'b1; bus.stall_req = '0; bus.flush_req = 1'b0; bus.flush_stage = '0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      cmp("post_reset_hang", bus.hang, 0);
      cmp("post_reset_sc", bus.stall_cycles, 0);
   endtask

   initial begin
      // rdy sreq flush fs | stall flush ack sc fc
      tbl[0]  = mk(1, 5'b01000, 0, 0, 5'b01111, 5'b00000, 0, 0, 0);
      tbl[1]  = mk(1, 5'b00010, 0, 0, 5'b00011, 5'b00000, 0, 1, 0);
      tbl[2]  = mk(1, 5'b00001, 0, 0, 5'b00001, 5'b00000, 0, 2, 0);
      tbl[3]  = mk(1, 5'b01010, 0, 0, 5'b01111, 5'b00000, 0, 3, 0);
      tbl[4]  = mk(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 0);
      tbl[5]  = mk(1, 5'b00000, 1, 2, 5'b00000, 5'b00011, 1, 4, 0);
      tbl[6]  = mk(1, 5'b00000, 0, 0, 5'b00000, 5'b00001, 0, 4, 1);
      tbl[7]  = mk(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 1);
      tbl[8]  = mk(1, 5'b01000, 1, 2, 5'b01111, 5'b00000, 0, 4, 1);
      tbl[9]  = mk(1, 5'b01000, 1, 2, 5'b01111, 5'b00000, 0, 5, 1);
      tbl[10] = mk(1, 5'b01000, 1, 2, 5'b01111, 5'b00000, 0, 6, 1);
      tbl[11] = mk(1, 5'b00000, 1, 2, 5'b00000, 5'b00011, 1, 7, 1);
      tbl[12] = mk(0, 5'b01000, 1, 2, 5'b11111, 5'b00000, 0, 7, 2);
      tbl[13] = mk(0, 5'b01000, 1, 2, 5'b11111, 5'b00000, 0, 7, 2);
      tbl[14] = mk(0, 5'b01000, 1, 2, 5'b11111, 5'b00000, 0, 7, 2);
      tbl[15] = mk(1, 5'b01000, 1, 2, 5'b01110, 5'b00001, 0, 7, 2);
      tbl[16] = mk(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 8, 2);
      tbl[17] = mk(1, 5'b00000, 1, 0, 5'b00000, 5'b00000, 1, 8, 2);
      tbl[18] = mk(1, 5'b00100, 1, 6, 5'b00111, 5'b00000, 1, 8, 3);
      tbl[19] = mk(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 9, 4);
      tbl[20] = mk(1, 5'b00010, 1, 3, 5'b00000, 5'b00111, 1, 9, 4);
      tbl[21] = mk(1, 5'b00010, 0, 0, 5'b00010, 5'b00001, 0, 10, 5);
      tbl[22] = mk(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 11, 5);
      tbl[23] = mk(1, 5'b00000, 1, 1, 5'b00000, 5'b00001, 1, 11, 5);
      tbl[24] = mk(1, 5'b00000, 1, 4, 5'b00000, 5'b01111, 1, 11, 6);
      tbl[25] = mk(1, 5'b00000, 0, 0, 5'b00000, 5'b00001, 0, 11, 7);
      tbl[26] = mk(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 11, 7);

      // Reset with a flush request present: full stall, no flush, no ack.
      rst_in = 1'b1;
      bus.rdy_in = 1'b1; bus.stall_req = '0; bus.flush_req = 1'b1; bus.flush_stage = 3'd2;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_in);
         cmp("reset_stall", bus.stall, 5'b11111);
         cmp("reset_flush", bus.flush, 5'b00000);
         cmp("reset_ack", bus.flush_ack, 0);
      end
      @(posedge clk_in);
      #1;
      rst_in = 1'b0; bus.flush_req = 1'b0; bus.flush_stage = '0;
      @(negedge clk_in);
      cmp("release_stall", bus.stall, 5'b00000);
      cmp("release_sc", bus.stall_cycles, 0);
      cmp("release_fc", bus.flush_count, 0);
      cmp("release_hang", bus.hang, 0);

      for (int i = 0; i < 27; i++) begin
         applyStimulus(tbl[i]);
         checkOutput(i);
      end

      // Reset in the middle of a hold drops flush[0] at once and aborts the hold.
      drive(1, 5'b00000, 1, 3'd2);
      @(negedge clk_in);
      cmp("mid_hold_ack", bus.flush_ack, 1);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1; bus.flush_req = 1'b0;
      @(negedge clk_in);
      cmp("mid_hold_rst_flush", bus.flush, 5'b00000);
      cmp("mid_hold_rst_stall", bus.stall, 5'b11111);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      cmp("after_abort_flush", bus.flush, 5'b00000);
      cmp("after_abort_fc", bus.flush_count, 0);

      // Paused cycles neither advance nor clear the watchdog: 5 + 3 stalls reach the limit.
      for (int i = 0; i < 5; i++) drive(1, 5'b00100, 0, 0);
      for (int i = 0; i < 2; i++) drive(0, 5'b00100, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 5'b00100, 0, 0);
      @(negedge clk_in);
      cmp("pause_wd_hang_before", bus.hang, 0);
      drive(1, 5'b00000, 0, 0);
      @(negedge clk_in);
      cmp("pause_wd_hang_after", bus.hang, 1);
      cmp("pause_wd_sc", bus.stall_cycles, 8);

      doReset();

      // Watchdog: 7 stalls, a gap, then 8 consecutive stalls.
      for (int i = 0; i < 7; i++) drive(1, 5'b00100, 0, 0);
      drive(1, 5'b00000, 0, 0);
      @(negedge clk_in);
      cmp("wd_gap_hang", bus.hang, 0);
      for (int i = 0; i < 8; i++) drive(1, 5'b00100, 0, 0);
      @(negedge clk_in);
      cmp("wd_8th_hang", bus.hang, 0);
      drive(1, 5'b00000, 0, 0);
      @(negedge clk_in);
      cmp("wd_trip_hang", bus.hang, 1);
      cmp("wd_sc", bus.stall_cycles, 15);
      repeat (3) drive(1, 5'b00000, 0, 0);
      @(negedge clk_in);
      cmp("wd_sticky_hang", bus.hang, 1);

      doReset();

      // Long stall saturates the 8-bit stall counter.
      for (int i = 0; i < 260; i++) drive(1, 5'b00001, 0, 0);
      drive(1, 5'b00000, 0, 0);
      @(negedge clk_in);
      cmp("sc_saturate", bus.stall_cycles, 255);
      cmp("sat_hang", bus.hang, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
